// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 grid sampler: RGB565 field layout,
// capture FSM encoding and the accumulator width helper.
package ov7670_pkg;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    // Line/column counters saturate, so any sensor geometry up to 2047 fits.
    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FRAME,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // A 2^w x 2^w window sum of a base_w-bit channel needs 2*w extra bits.
    function automatic int acc_width(input int base_w, input int win_log2);
        return base_w + 2 * win_log2;
    endfunction

endpackage

// File: rtl/ov7670_pixel_assembler.sv
// Camera-side front end: synchronises VSYNC/HREF/PCLK/D, detects PCLK rising
// edges, pairs bytes into RGB565 pixels and tracks line/column position.
module ov7670_pixel_assembler
    import ov7670_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             vsync_in,
    input  logic             href_in,
    input  logic             pclk_in,
    input  logic [7:0]       d_in,
    output logic             vsync_rise,
    output logic             vsync_fall,
    output logic             pix_valid,
    output logic [15:0]      pix_data,
    output logic [CNT_W-1:0] pix_line,
    output logic [CNT_W-1:0] pix_col
);

    // [0],[1] synchroniser stages, [2] history for edge detection
    logic [2:0]       vs_q, hr_q, pc_q;
    logic [7:0]       d_q1, d_q2, hi_byte;
    logic             byte_phase;
    logic [CNT_W-1:0] line_cnt, col_cnt;
    logic             href_rise, href_fall, pclk_rise;

    assign vsync_rise = vs_q[1] & ~vs_q[2];
    assign vsync_fall = ~vs_q[1] & vs_q[2];
    assign href_rise  = hr_q[1] & ~hr_q[2];
    assign href_fall  = ~hr_q[1] & hr_q[2];
    assign pclk_rise  = pc_q[1] & ~pc_q[2];

    // Synchronisers; D is delayed by the same two stages so it lines up with
    // the synchronised PCLK edge and is sampled while still stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vs_q <= '0;
            hr_q <= '0;
            pc_q <= '0;
            d_q1 <= '0;
            d_q2 <= '0;
        end else begin
            vs_q <= {vs_q[1:0], vsync_in};
            hr_q <= {hr_q[1:0], href_in};
            pc_q <= {pc_q[1:0], pclk_in};
            d_q1 <= d_in;
            d_q2 <= d_q1;
        end
    end

    // Line counter: cleared at frame start, advanced at the end of each line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            line_cnt <= '0;
        else if (vsync_fall)
            line_cnt <= '0;
        else if (href_fall && line_cnt != '1)
            line_cnt <= line_cnt + 1'b1;
    end

    // Byte pairing: high byte first after HREF rise, low byte completes a pixel.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_phase <= 1'b0;
            hi_byte    <= '0;
            col_cnt    <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_line   <= '0;
            pix_col    <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (href_rise) begin
                byte_phase <= 1'b0;
                col_cnt    <= '0;
            end else if (pclk_rise && hr_q[1]) begin
                if (!byte_phase) begin
                    hi_byte    <= d_q2;
                    byte_phase <= 1'b1;
                end else begin
                    byte_phase <= 1'b0;
                    pix_valid  <= 1'b1;
                    pix_data   <= {hi_byte, d_q2};
                    pix_line   <= line_cnt;
                    pix_col    <= col_cnt;
                    if (col_cnt != '1)
                        col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ov7670_grid_sampler.sv
// Samples a GRID x GRID lattice of RGB565 points from one OV7670 frame into
// an internal register file. Define OV_GRID_AVG_EN to average a
// 2^WIN_LOG2 square window per cell; otherwise the origin pixel is stored.
module ov7670_grid_sampler
    import ov7670_pkg::*;
#(
    parameter int LINES    = 140,
    parameter int COLUMNS  = 320,
    parameter int GRID     = 3,
    parameter int ROW0     = 32,
    parameter int ROW_STEP = 47,
    parameter int COL0     = 65,
    parameter int COL_STEP = 84,
    parameter int WIN_LOG2 = 1,
    parameter int S_DATA   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic              PCLK,
    input  logic [7:0]        D,
    input  logic [2:0]        rd_row,
    input  logic [2:0]        rd_col,
    output logic [S_DATA-1:0] rd_pixel,
    output logic              busy,
    output logic              done,
    output logic              incomplete
);

`ifdef OV_GRID_AVG_EN
    localparam int WL = WIN_LOG2;
`else
    localparam int WL = 0;
`endif
    localparam int WIN = 1 << WL;

    generate
        if (GRID < 2 || GRID > 8) begin : g_grid_chk
            $error("GRID must be in 2..8");
        end
        if (WIN_LOG2 < 0 || WIN_LOG2 > 2) begin : g_win_chk
            $error("WIN_LOG2 must be in 0..2");
        end
        if (ROW0 + (GRID - 1) * ROW_STEP + WIN > LINES) begin : g_row_chk
            $error("sample lattice exceeds LINES");
        end
        if (COL0 + (GRID - 1) * COL_STEP + WIN > COLUMNS) begin : g_col_chk
            $error("sample lattice exceeds COLUMNS");
        end
    endgenerate

    logic             vsync_rise, vsync_fall, pix_valid;
    logic [15:0]      pix_data;
    logic [CNT_W-1:0] pix_line, pix_col;

    ov7670_pixel_assembler u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .vsync_in   (VSYNC),
        .href_in    (HREF),
        .pclk_in    (PCLK),
        .d_in       (D),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_line   (pix_line),
        .pix_col    (pix_col)
    );

    state_t                               state, state_n;
    logic [GRID-1:0]                      row_hit, col_hit;
    logic                                 row_last, col_last, in_range;
    logic                                 cap_pix, cap_wr, last_wr;
    logic [GRID-1:0][15:0]                wr_pix;
    logic [GRID-1:0][GRID-1:0][S_DATA-1:0] cells;
    logic [S_DATA-1:0]                    rd_next;

    // Locate the current pixel inside the lattice (windows never overlap).
    always_comb begin
        row_hit  = '0;
        col_hit  = '0;
        row_last = 1'b0;
        col_last = 1'b0;
        for (int i = 0; i < GRID; i++) begin
            if (int'(pix_line) >= ROW0 + i * ROW_STEP &&
                int'(pix_line) <  ROW0 + i * ROW_STEP + WIN) row_hit[i] = 1'b1;
            if (int'(pix_line) == ROW0 + i * ROW_STEP + WIN - 1) row_last = 1'b1;
            if (int'(pix_col) >= COL0 + i * COL_STEP &&
                int'(pix_col) <  COL0 + i * COL_STEP + WIN) col_hit[i] = 1'b1;
            if (int'(pix_col) == COL0 + i * COL_STEP + WIN - 1) col_last = 1'b1;
        end
    end

    assign in_range = int'(pix_line) < LINES && int'(pix_col) < COLUMNS;
    assign cap_pix  = state == ST_CAPTURE && pix_valid && in_range &&
                      (|row_hit) && (|col_hit);
    assign cap_wr   = cap_pix && row_last && col_last;
    assign last_wr  = cap_wr && row_hit[GRID-1] && col_hit[GRID-1];

`ifdef OV_GRID_AVG_EN
    localparam int RW = acc_width(R_W, WL);
    localparam int GW = acc_width(G_W, WL);
    localparam int BW = acc_width(B_W, WL);

    logic                  row_first, col_first;
    logic [GRID-1:0][RW-1:0] acc_r, sum_r;
    logic [GRID-1:0][GW-1:0] acc_g, sum_g;
    logic [GRID-1:0][BW-1:0] acc_b, sum_b;

    // Window sums; the first window pixel restarts the sum instead of adding.
    always_comb begin
        row_first = 1'b0;
        col_first = 1'b0;
        for (int i = 0; i < GRID; i++) begin
            if (int'(pix_line) == ROW0 + i * ROW_STEP) row_first = 1'b1;
            if (int'(pix_col)  == COL0 + i * COL_STEP) col_first = 1'b1;
        end
        for (int c = 0; c < GRID; c++) begin
            sum_r[c] = ((row_first && col_first) ? '0 : acc_r[c]) +
                       RW'(pix_data[R_LSB +: R_W]);
            sum_g[c] = ((row_first && col_first) ? '0 : acc_g[c]) +
                       GW'(pix_data[G_LSB +: G_W]);
            sum_b[c] = ((row_first && col_first) ? '0 : acc_b[c]) +
                       BW'(pix_data[B_LSB +: B_W]);
            // Top bits of each sum are the truncated mean.
            wr_pix[c] = {sum_r[c][RW-1 -: R_W], sum_g[c][GW-1 -: G_W],
                         sum_b[c][BW-1 -: B_W]};
        end
    end

    // Per-column accumulators, reused by every row band.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else if (cap_pix) begin
            for (int c = 0; c < GRID; c++) begin
                if (col_hit[c]) begin
                    acc_r[c] <= sum_r[c];
                    acc_g[c] <= sum_g[c];
                    acc_b[c] <= sum_b[c];
                end
            end
        end
    end
`else
    // Single-pixel sampling: the origin pixel is the cell value.
    always_comb begin
        for (int c = 0; c < GRID; c++)
            wr_pix[c] = pix_data;
    end
`endif

    // Cell register file.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cells <= '0;
        end else if (cap_wr) begin
            for (int r = 0; r < GRID; r++)
                for (int c = 0; c < GRID; c++)
                    if (row_hit[r] && col_hit[c])
                        cells[r][c] <= S_DATA'(wr_pix[c]);
        end
    end

    // Read mux; addresses outside the lattice return 0.
    always_comb begin
        rd_next = '0;
        for (int r = 0; r < GRID; r++)
            for (int c = 0; c < GRID; c++)
                if (rd_row == 3'(r) && rd_col == 3'(c))
                    rd_next = cells[r][c];
    end

    // Registered read port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            rd_pixel <= '0;
        else
            rd_pixel <= rd_next;
    end

    // Incomplete flag: set when the frame ends early, cleared by a new start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            incomplete <= 1'b0;
        else if (state == ST_IDLE && start)
            incomplete <= 1'b0;
        else if (state == ST_CAPTURE && vsync_rise && !last_wr)
            incomplete <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_n;
    end

    // FSM next state and status outputs.
    always_comb begin
        state_n = state;
        busy    = state != ST_IDLE;
        done    = state == ST_DONE;
        case (state)
            ST_IDLE:       if (start) state_n = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (vsync_fall) state_n = ST_CAPTURE;
            ST_CAPTURE:    if (last_wr || vsync_rise) state_n = ST_DONE;
            ST_DONE:       state_n = ST_IDLE;
            default:       state_n = ST_IDLE;
        endcase
    end

endmodule
